// File: rtl/alu_issuer.sv
// Command-side initiator for the 4-bit ALU: latches a command onto the ALU, waits SETTLE cycles,
// captures the result and returns it with its tag; also keeps op/overflow counters for display.
module alu_issuer #(
    parameter int W      = 4,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    input  logic [1:0]   cmd_tag,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_ctrl,
    input  logic [W-1:0] alu_res,
    input  logic         alu_car,
    input  logic         alu_of,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_res,
    output logic         rsp_car,
    output logic         rsp_of,
    output logic [1:0]   rsp_tag,
    input  logic         cnt_clr,
    output logic [7:0]   cnt_ops,
    output logic [7:0]   cnt_of
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [2:0] SETTLE_INIT = 3'(SETTLE - 1);

    state_t         state_q;
    logic [2:0]     settle_q;
    logic [1:0]     tag_q;
    logic [W-1:0]   alu_a_q;
    logic [W-1:0]   alu_b_q;
    logic [2:0]     alu_ctrl_q;
    logic [W-1:0]   rsp_res_q;
    logic           rsp_car_q;
    logic           rsp_of_q;
    logic [1:0]     rsp_tag_q;
    logic [7:0]     cnt_ops_q;
    logic [7:0]     cnt_ops_d;
    logic [7:0]     cnt_of_q;
    logic [7:0]     cnt_of_d;
    logic           pop_s;

    // Handshake flags come only from registered state, never from the peer's valid/ready.
    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign pop_s     = (state_q == S_RESP) && rsp_ready;

    // Issue/settle/capture/response FSM with its datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            settle_q   <= 3'd0;
            tag_q      <= 2'd0;
            alu_a_q    <= {W{1'b0}};
            alu_b_q    <= {W{1'b0}};
            alu_ctrl_q <= 3'b000;
            rsp_res_q  <= {W{1'b0}};
            rsp_car_q  <= 1'b0;
            rsp_of_q   <= 1'b0;
            rsp_tag_q  <= 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        alu_a_q    <= cmd_a;
                        alu_b_q    <= cmd_b;
                        alu_ctrl_q <= cmd_op;
                        tag_q      <= cmd_tag;
                        settle_q   <= SETTLE_INIT;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (settle_q != 3'd0) begin
                        settle_q <= settle_q - 3'd1;
                    end else begin
                        rsp_res_q <= alu_res;
                        rsp_car_q <= alu_car;
                        rsp_of_q  <= alu_of;
                        rsp_tag_q <= tag_q;
                        state_q   <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Counter next-state: clear beats a coincident pop; ops wraps, overflow count saturates.
    always_comb begin
        cnt_ops_d = cnt_ops_q;
        cnt_of_d  = cnt_of_q;
        if (cnt_clr) begin
            cnt_ops_d = 8'd0;
            cnt_of_d  = 8'd0;
        end else if (pop_s) begin
            cnt_ops_d = cnt_ops_q + 8'd1;
            if (rsp_of_q && (cnt_of_q != 8'hFF)) begin
                cnt_of_d = cnt_of_q + 8'd1;
            end else begin
                cnt_of_d = cnt_of_q;
            end
        end else begin
            cnt_ops_d = cnt_ops_q;
            cnt_of_d  = cnt_of_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_ops_q <= 8'd0;
            cnt_of_q  <= 8'd0;
        end else begin
            cnt_ops_q <= cnt_ops_d;
            cnt_of_q  <= cnt_of_d;
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_ctrl = alu_ctrl_q;
    assign rsp_res  = rsp_res_q;
    assign rsp_car  = rsp_car_q;
    assign rsp_of   = rsp_of_q;
    assign rsp_tag  = rsp_tag_q;
    assign cnt_ops  = cnt_ops_q;
    assign cnt_of   = cnt_of_q;

endmodule
